// File: rtl/llm_int8_dequant_gather.sv
// -----------------------------------------------------------------------------
// llm_int8_dequant_gather
//
// Recombines the two result streams of the int8 mixed-precision matmul:
//   * the high-precision outlier partial product ("large"), and
//   * the int8-path accumulator ("small") with its power-of-two scale.
// Each stream is buffered in its own FIFO, beats are paired strictly in
// order, the small beat is dequantised (arithmetic left shift by its scale),
// added to the large beat, and the sum is emitted through a registered
// output stage.
//
// Optional feature macro: LLM_GATHER_SATURATE_EN
//   defined   : each output element is clamped to the signed OUT_WIDTH range
//               and sat_flag records (sticky) any out-of-range sum.
//   undefined : each output element wraps to OUT_WIDTH bits; sat_flag = 0.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   data_in_large[_valid|_ready]   large beat, N x OUT_WIDTH, element i at
//                                  bits [i*OUT_WIDTH +: OUT_WIDTH]
//   data_in_small[_scale|_valid|_ready]
//                                  small beat, N x ACC_WIDTH, plus its shift
//   data_out[_valid|_ready]        recombined beat, N x OUT_WIDTH
//   sat_flag              sticky saturation indicator
//
// Handshake: every stream uses valid/ready; a beat transfers on the rising
// edge where valid && ready are both 1. Producers hold data stable while
// valid is high and ready is low. Input ready depends only on the FIFO
// occupancy count, so it never combinationally depends on any valid.
// -----------------------------------------------------------------------------
module llm_int8_dequant_gather #(
  parameter int OUT_WIDTH   = 32,
  parameter int ACC_WIDTH   = 16,
  parameter int SCALE_WIDTH = 4,
  parameter int OUT_ROWS    = 2,
  parameter int OUT_COLUMNS = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [OUT_ROWS*OUT_COLUMNS*OUT_WIDTH-1:0]    data_in_large,
  input  logic                                         data_in_large_valid,
  output logic                                         data_in_large_ready,
  input  logic [OUT_ROWS*OUT_COLUMNS*ACC_WIDTH-1:0]    data_in_small,
  input  logic [SCALE_WIDTH-1:0]                       data_in_small_scale,
  input  logic                                         data_in_small_valid,
  output logic                                         data_in_small_ready,
  output logic [OUT_ROWS*OUT_COLUMNS*OUT_WIDTH-1:0]    data_out,
  output logic                                         data_out_valid,
  input  logic                                         data_out_ready,
  output logic                                         sat_flag
);

  localparam int N   = OUT_ROWS * OUT_COLUMNS;
  localparam int LW  = N * OUT_WIDTH;
  localparam int SDW = N * ACC_WIDTH;
  localparam int SEW = SCALE_WIDTH + SDW;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef LLM_GATHER_SATURATE_EN
  // Two guard bits above OUT_WIDTH make every sum exact so range can be judged.
  localparam int SUM_W = OUT_WIDTH + 2;
  localparam int SH_W  = OUT_WIDTH + 1;
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`else
  // Wrapping keeps only the low OUT_WIDTH bits, which the guard bits of the
  // exact sum never influence, so the arithmetic is carried at OUT_WIDTH.
  localparam int SUM_W = OUT_WIDTH;
  localparam int SH_W  = OUT_WIDTH;
`endif

  logic fire;

  // ---------------------------------------------------------------------------
  // Large FIFO
  // ---------------------------------------------------------------------------
  logic [LW-1:0] large_mem [FIFO_DEPTH];
  logic [PW-1:0] large_wr_ptr;
  logic [PW-1:0] large_rd_ptr;
  logic [CW-1:0] large_count;
  logic          large_push;
  logic          large_nonempty;
  logic [LW-1:0] large_head;

  assign data_in_large_ready = (large_count != FULL_CNT);
  assign large_push          = data_in_large_valid && data_in_large_ready;
  assign large_nonempty      = (large_count != '0);
  assign large_head          = large_mem[large_rd_ptr];

  always_ff @(posedge clk) begin
    if (large_push) large_mem[large_wr_ptr] <= data_in_large;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      large_wr_ptr <= '0;
      large_rd_ptr <= '0;
      large_count  <= '0;
    end else begin
      if (large_push) large_wr_ptr <= large_wr_ptr + 1'b1;
      if (fire)       large_rd_ptr <= large_rd_ptr + 1'b1;
      case ({large_push, fire})
        2'b10:   large_count <= large_count + 1'b1;
        2'b01:   large_count <= large_count - 1'b1;
        default: large_count <= large_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Small FIFO: each entry is {scale, data} so the shift travels with its beat
  // ---------------------------------------------------------------------------
  logic [SEW-1:0]         small_mem [FIFO_DEPTH];
  logic [PW-1:0]          small_wr_ptr;
  logic [PW-1:0]          small_rd_ptr;
  logic [CW-1:0]          small_count;
  logic                   small_push;
  logic                   small_nonempty;
  logic [SEW-1:0]         small_entry;
  logic [SDW-1:0]         small_data;
  logic [SCALE_WIDTH-1:0] small_scale;

  assign data_in_small_ready = (small_count != FULL_CNT);
  assign small_push          = data_in_small_valid && data_in_small_ready;
  assign small_nonempty      = (small_count != '0);
  assign small_entry         = small_mem[small_rd_ptr];
  assign small_data          = small_entry[SDW-1:0];
  assign small_scale         = small_entry[SEW-1:SDW];

  always_ff @(posedge clk) begin
    if (small_push) small_mem[small_wr_ptr] <= {data_in_small_scale, data_in_small};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      small_wr_ptr <= '0;
      small_rd_ptr <= '0;
      small_count  <= '0;
    end else begin
      if (small_push) small_wr_ptr <= small_wr_ptr + 1'b1;
      if (fire)       small_rd_ptr <= small_rd_ptr + 1'b1;
      case ({small_push, fire})
        2'b10:   small_count <= small_count + 1'b1;
        2'b01:   small_count <= small_count - 1'b1;
        default: small_count <= small_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pairing: pop both heads when each FIFO has a beat and the output register
  // is free or is being drained this cycle.
  // ---------------------------------------------------------------------------
  assign fire = large_nonempty && small_nonempty && (!data_out_valid || data_out_ready);

  // ---------------------------------------------------------------------------
  // Dequantise and sum the paired heads
  // ---------------------------------------------------------------------------
  logic [N-1:0][SH_W-1:0]  shifted;
  logic [N-1:0][SUM_W-1:0] sum;
  logic [LW-1:0]           result;
`ifdef LLM_GATHER_SATURATE_EN
  logic                    any_ovf;
`endif

  always_comb begin
    shifted = '0;
    sum     = '0;
    result  = '0;
`ifdef LLM_GATHER_SATURATE_EN
    any_ovf = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      // Bits shifted above SH_W are dropped by the assignment width.
      shifted[i] = SH_W'($signed(small_data[i*ACC_WIDTH +: ACC_WIDTH])) <<< small_scale;
      sum[i]     = SUM_W'($signed(large_head[i*OUT_WIDTH +: OUT_WIDTH]))
                 + SUM_W'($signed(shifted[i]));
`ifdef LLM_GATHER_SATURATE_EN
      // In range exactly when the bits from OUT_WIDTH-1 upward are all equal.
      if ((sum[i][SUM_W-1:OUT_WIDTH-1] != '0) && (sum[i][SUM_W-1:OUT_WIDTH-1] != '1)) begin
        any_ovf = 1'b1;
        result[i*OUT_WIDTH +: OUT_WIDTH] = sum[i][SUM_W-1] ? SAT_MIN : SAT_MAX;
      end else begin
        result[i*OUT_WIDTH +: OUT_WIDTH] = sum[i][OUT_WIDTH-1:0];
      end
`else
      result[i*OUT_WIDTH +: OUT_WIDTH] = sum[i];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: loads on fire, holds while stalled, empties when drained
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (fire) begin
      data_out       <= result;
      data_out_valid <= 1'b1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

`ifdef LLM_GATHER_SATURATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (fire && any_ovf) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_llm_int8_dequant_gather.sv
// -----------------------------------------------------------------------------
// tb_llm_int8_dequant_gather
//
// Bench for llm_int8_dequant_gather (OUT_WIDTH=32, ACC_WIDTH=16, N=2,
// FIFO_DEPTH=4). Accepted input beats feed a reference model that pairs them
// in order and computes each expected output with plain integer arithmetic;
// a monitor compares every output transfer against the expected queue.
// Honours LLM_GATHER_SATURATE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_llm_int8_dequant_gather;

  localparam int OW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst;
  logic [2*OW-1:0] data_in_large;
  logic          data_in_large_valid;
  logic          data_in_large_ready;
  logic [2*AW-1:0] data_in_small;
  logic [SW-1:0] data_in_small_scale;
  logic          data_in_small_valid;
  logic          data_in_small_ready;
  logic [2*OW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          sat_flag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  llm_int8_dequant_gather #(
    .OUT_WIDTH(OW), .ACC_WIDTH(AW), .SCALE_WIDTH(SW),
    .OUT_ROWS(2), .OUT_COLUMNS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_in_large       (data_in_large),
    .data_in_large_valid (data_in_large_valid),
    .data_in_large_ready (data_in_large_ready),
    .data_in_small       (data_in_small),
    .data_in_small_scale (data_in_small_scale),
    .data_in_small_valid (data_in_small_valid),
    .data_in_small_ready (data_in_small_ready),
    .data_out            (data_out),
    .data_out_valid      (data_out_valid),
    .data_out_ready      (data_out_ready),
    .sat_flag            (sat_flag)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int passes = 0;
  logic [63:0] large_q[$];
  logic [35:0] small_q[$];
  logic [64:0] exp_q[$];     // {expected sat_flag, expected data_out}
  bit          model_sat = 0;
  bit          last_al;
  bit          last_as;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected result of one pair, computed with exact integer arithmetic.
  function automatic logic [64:0] ref_beat(input logic [63:0] lg, input logic [35:0] sm);
    logic [63:0] r;
    logic        ovf;
    longint      a, b, s, total;
    int          sc;
    r   = '0;
    ovf = 1'b0;
    sc  = int'(sm[35:32]);
    for (int i = 0; i < 2; i++) begin
      a     = longint'($signed(lg[i*32 +: 32]));
      b     = longint'($signed(sm[i*16 +: 16]));
      s     = b * (longint'(1) << sc);
      total = a + s;
`ifdef LLM_GATHER_SATURATE_EN
      if (total > 64'sd2147483647) begin
        r[i*32 +: 32] = 32'h7fffffff;
        ovf = 1'b1;
      end else if (total < -64'sd2147483648) begin
        r[i*32 +: 32] = 32'h80000000;
        ovf = 1'b1;
      end else begin
        r[i*32 +: 32] = total[31:0];
      end
`else
      r[i*32 +: 32] = total[31:0];
`endif
    end
    return {ovf, r};
  endfunction

  function automatic void pair_model();
    logic [64:0] res;
    while (large_q.size() != 0 && small_q.size() != 0) begin
      res = ref_beat(large_q.pop_front(), small_q.pop_front());
`ifdef LLM_GATHER_SATURATE_EN
      model_sat = model_sat | res[64];
`endif
      exp_q.push_back({model_sat, res[63:0]});
    end
  endfunction

  function automatic void model_reset();
    large_q.delete();
    small_q.delete();
    exp_q.delete();
    model_sat = 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 2 time units after a rising edge
  // ---------------------------------------------------------------------------
  task automatic tick();
    bit al;
    bit as;
    al = data_in_large_valid && data_in_large_ready && !rst;
    as = data_in_small_valid && data_in_small_ready && !rst;
    @(posedge clk);
    last_al = al;
    last_as = as;
    if (al) large_q.push_back(data_in_large);
    if (as) small_q.push_back({data_in_small_scale, data_in_small});
    pair_model();
    #2;
  endtask

  task automatic new_large();
    data_in_large = {$urandom(), $urandom()};
  endtask

  task automatic new_small();
    data_in_small       = $urandom();
    data_in_small_scale = SW'($urandom_range(0, 15));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    data_out_ready = 1'b1;
    while ((exp_q.size() != 0 || data_out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_idle", 64'(data_out_valid), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares each output transfer and checks stall stability
  // ---------------------------------------------------------------------------
  bit          held = 0;
  logic [63:0] held_data;
  logic [64:0] e;

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(data_out_valid), 64'd1);
        chk("hold_data", data_out, held_data);
      end
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got %0h expected none", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", data_out, e[63:0]);
          chk("sat_flag", 64'(sat_flag), 64'(e[64]));
        end
      end
      held      = data_out_valid && !data_out_ready;
      held_data = data_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int sent;
    rst = 1'b1;
    data_in_large = '0;
    data_in_large_valid = 1'b0;
    data_in_small = '0;
    data_in_small_scale = '0;
    data_in_small_valid = 1'b0;
    data_out_ready = 1'b1;
    #1;
    chk("rst_valid", 64'(data_out_valid), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);
    #21 rst = 1'b0;
    tick();
    chk("rst_large_ready", 64'(data_in_large_ready), 64'd1);
    chk("rst_small_ready", 64'(data_in_small_ready), 64'd1);

    // Aligned beat: {10,-5} + {3,-2}<<2 = {22,-13}, two edges of latency.
    data_in_large       = {32'hFFFFFFFB, 32'd10};
    data_in_small       = {16'hFFFE, 16'd3};
    data_in_small_scale = 4'd2;
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    tick();
    chk("aligned_accept", 64'(last_al && last_as), 64'd1);
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    chk("aligned_lat_edge1", 64'(data_out_valid), 64'd0);
    tick();
    chk("aligned_lat_edge2", 64'(data_out_valid), 64'd1);
    chk("aligned_data", data_out, {32'hFFFFFFF3, 32'd22});
    tick();
    chk("aligned_one_cycle", 64'(data_out_valid), 64'd0);

    // Skew: large beats with no small beats fill the large FIFO.
    for (int k = 1; k <= 4; k++) begin
      data_in_large       = {32'd0, 32'(k)};
      data_in_large_valid = 1'b1;
      chk("skew_ready", 64'(data_in_large_ready), 64'd1);
      tick();
    end
    data_in_large = {32'd0, 32'd5};
    chk("skew_full", 64'(data_in_large_ready), 64'd0);
    repeat (3) tick();
    chk("skew_still_full", 64'(data_in_large_ready), 64'd0);
    chk("skew_no_output", 64'(data_out_valid), 64'd0);
    data_in_small       = '0;
    data_in_small_scale = '0;
    data_in_small_valid = 1'b1;
    sent = 0;
    n = 0;
    while (sent < 4 && n < 20) begin
      tick();
      if (last_as) sent++;
      if (last_al) data_in_large_valid = 1'b0;
      n++;
    end
    data_in_small_valid = 1'b0;
    chk("skew_small_sent", 64'(sent), 64'd4);
    n = 0;
    while (data_in_large_valid && n < 10) begin
      tick();
      if (last_al) data_in_large_valid = 1'b0;
      n++;
    end
    chk("skew_fifth_accepted", 64'(data_in_large_valid), 64'd0);
    data_in_small_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_as && n < 10);
    data_in_small_valid = 1'b0;
    drain(30);

    // Backpressure: output stalled while both inputs stream.
    data_out_ready = 1'b0;
    new_large();
    new_small();
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    repeat (6) begin
      tick();
      if (last_al) new_large();
      if (last_as) new_small();
    end
    chk("bp_large_ready", 64'(data_in_large_ready), 64'd0);
    chk("bp_small_ready", 64'(data_in_small_ready), 64'd0);
    data_out_ready = 1'b1;
    repeat (12) begin
      tick();
      if (last_al) new_large();
      if (last_as) new_small();
    end
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    drain(40);

    // Overflow: 0x7FFFFFF0 + 0x20.
    data_in_large       = {32'd0, 32'h7FFFFFF0};
    data_in_small       = {16'd0, 16'h0020};
    data_in_small_scale = 4'd0;
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    tick();
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    tick();
    chk("ovf_valid", 64'(data_out_valid), 64'd1);
`ifdef LLM_GATHER_SATURATE_EN
    chk("ovf_data", 64'(data_out[31:0]), 64'h7FFFFFFF);
    chk("ovf_sat", 64'(sat_flag), 64'd1);
`else
    chk("ovf_data", 64'(data_out[31:0]), 64'h80000010);
    chk("ovf_sat", 64'(sat_flag), 64'd0);
`endif
    drain(10);

    // Random traffic with random output backpressure.
    repeat (400) begin
      data_out_ready = ($urandom_range(0, 3) != 0);
      if (!data_in_large_valid || last_al) begin
        data_in_large_valid = 1'($urandom_range(0, 1));
        new_large();
      end
      if (!data_in_small_valid || last_as) begin
        data_in_small_valid = 1'($urandom_range(0, 1));
        new_small();
      end
      tick();
    end
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    drain(100);

    // Reset mid-stream: one beat in the output register, three buffered.
    data_out_ready = 1'b0;
    new_large();
    new_small();
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    n = 0;
    sent = 0;
    while ((data_in_large_valid || data_in_small_valid) && n < 20) begin
      tick();
      if (last_al) begin
        sent++;
        if (sent >= 4) data_in_large_valid = 1'b0;
        else new_large();
      end
      if (last_as) begin
        if (small_q.size() + exp_q.size() >= 4) data_in_small_valid = 1'b0;
        else new_small();
      end
      n++;
    end
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    tick();
    chk("mid_valid_before", 64'(data_out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(data_out_valid), 64'd0);
    chk("mid_rst_data", data_out, 64'd0);
    chk("mid_rst_sat", 64'(sat_flag), 64'd0);
    model_reset();
    #10 rst = 1'b0;
    data_out_ready = 1'b1;
    tick();
    chk("mid_large_ready", 64'(data_in_large_ready), 64'd1);
    chk("mid_small_ready", 64'(data_in_small_ready), 64'd1);
    data_in_large       = {32'd100, 32'hFFFFFF9C};
    data_in_small       = {16'hFFFF, 16'd7};
    data_in_small_scale = 4'd3;
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    tick();
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    tick();
    chk("mid_fresh_data", data_out, {32'd92, 32'hFFFFFFD4});
    drain(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
